// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative multiply/divide unit with HI/LO result registers.
//
// Ports:
//   clock     - system clock, all state changes on the rising edge
//   reset     - synchronous, active-high; wins over every other input
//   start     - request, sampled only while idle and not busy
//   op[1:0]   - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      - multiplicand/dividend and multiplier/divisor (latched at start)
//   busy      - high while an operation is in flight
//   done      - one-cycle pulse when hi/lo are written (or a trap aborts)
//   hi, lo    - product upper/lower half, or remainder/quotient
//   div_zero  - one-cycle pulse on a trapped divide by zero
//
// Configuration macro MULT_DIV_DIVZERO_TRAP_EN:
//   defined   - DIV/DIVU with b == 0 aborts one cycle after start, hi/lo untouched
//   undefined - b == 0 runs the full sequence (hi = a, lo = all ones), div_zero = 0
//
// Latency is XLEN+2 edges from the start edge: XLEN iterations, sign fix, write-back.
// Requires XLEN >= 2.
module mult_div_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_zero
);

    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StWb
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;          // negate product / quotient at fix
    logic            neg_rem_q, neg_rem_d;  // negate remainder at fix
    logic [XLEN-1:0] opb_q, opb_d;          // multiplicand or divisor magnitude
    logic [XLEN-1:0] rem_q, rem_d;          // product upper half / partial remainder
    logic [XLEN-1:0] quo_q, quo_d;          // multiplier / dividend shifting to quotient
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            div_zero_q, div_zero_d;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
    logic            trap_q, trap_d;
`endif

    // Datapath helpers
    logic              is_signed, is_div_op, sign_a, sign_b, b_zero, trap_pending;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] prod_neg;

    always_comb begin
        is_signed = ~op[0];
        is_div_op = op[1];
        sign_a    = is_signed & a[XLEN-1];
        sign_b    = is_signed & b[XLEN-1];
        b_zero    = (b == '0);
        mag_a     = sign_a ? -a : a;
        mag_b     = sign_b ? -b : b;

        // Shift-add: add multiplicand to upper half when multiplier LSB is set.
        mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
        // Restoring step: bring in next dividend bit, trial-subtract divisor.
        div_shift = {rem_q, quo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        prod_neg  = -{rem_q, quo_q};
`ifdef MULT_DIV_DIVZERO_TRAP_EN
        trap_pending = trap_q;
`else
        trap_pending = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        opb_d      = opb_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
        trap_d     = trap_q;
`endif

        case (state_q)
            StIdle: begin
                if (trap_pending) begin
`ifdef MULT_DIV_DIVZERO_TRAP_EN
                    trap_d = 1'b0;
`endif
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    div_zero_d = 1'b1;
                end else if (start && !busy_q) begin
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    is_div_d  = is_div_op;
                    rem_d     = '0;
                    neg_rem_d = sign_a;
                    if (is_div_op) begin
                        opb_d   = mag_b;
                        quo_d   = mag_a;
                        // b == 0 keeps the all-ones quotient un-negated.
                        neg_d   = (sign_a ^ sign_b) & ~b_zero;
                        state_d = StDiv;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
                        if (b_zero) begin
                            trap_d  = 1'b1;
                            state_d = StIdle;
                        end
`endif
                    end else begin
                        opb_d   = mag_a;
                        quo_d   = mag_b;
                        neg_d   = sign_a ^ sign_b;
                        state_d = StMul;
                    end
                end
            end

            StMul: begin
                rem_d = mul_sum[XLEN:1];
                quo_d = {mul_sum[0], quo_q[XLEN-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(XLEN - 1)) begin
                    state_d = StFix;
                end
            end

            StDiv: begin
                if (!div_diff[XLEN]) begin
                    rem_d = div_diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = div_shift[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(XLEN - 1)) begin
                    state_d = StFix;
                end
            end

            StFix: begin
                if (is_div_q) begin
                    if (neg_q) begin
                        quo_d = -quo_q;
                    end
                    if (neg_rem_q) begin
                        rem_d = -rem_q;
                    end
                end else if (neg_q) begin
                    {rem_d, quo_d} = prod_neg;
                end
                state_d = StWb;
            end

            StWb: begin
                hi_d    = rem_q;
                lo_d    = quo_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            opb_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            opb_q      <= opb_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
            trap_q     <= trap_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: stimulus pushes expected results computed
// with plain integer arithmetic; a negedge monitor pops and compares on each done.
module tb_mult_div_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    mult_div_ctrl #(.XLEN(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] last_hi = 32'h0;
    logic [31:0] last_lo = 32'h0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: results straight from integer multiply/divide.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output exp_t e);
        logic [63:0] p;
        longint      sx, sy, q, r;
        logic [63:0] qv, rv;
        e.dz  = 1'b0;
        e.due = 34;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin
                p = 64'(sx * sy);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'h0, x} * {32'h0, y};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (y == 32'h0) begin
`ifdef MULT_DIV_DIVZERO_TRAP_EN
                    e.hi  = last_hi;
                    e.lo  = last_lo;
                    e.dz  = 1'b1;
                    e.due = 1;
`else
                    e.hi = x;
                    e.lo = 32'hFFFF_FFFF;
`endif
                end else if (o == 2'b10) begin
                    q = sx / sy;
                    r = sx % sy;
                    qv = q;
                    rv = r;
                    e.lo = qv[31:0];
                    e.hi = rv[31:0];
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    // Called away from a rising edge; E0 is the next rising edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clock);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        model(o, x, y, e);
        e.due = cyc + e.due;
        sb.push_back(e);
        if (e.due - cyc != 1) check("busy_after_start", {63'h0, busy}, 64'h1);
    endtask

    // Waits for done while scrambling operands; returns at the done-cycle negedge.
    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done) return;
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
        end
        tests++;
        fails++;
        $display("FAIL done_timeout: got no done within 100 cycles, required done");
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clock) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, required no done (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("hi", {32'h0, hi}, {32'h0, mon_e.hi});
                check("lo", {32'h0, lo}, {32'h0, mon_e.lo});
                check("div_zero", {63'h0, div_zero}, {63'h0, mon_e.dz});
                check("done_cycle", 64'(cyc), 64'(mon_e.due));
                check("busy_at_done", {63'h0, busy}, 64'h0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_div_zero", {63'h0, div_zero}, 64'h0);
        check("rst_hi", {32'h0, hi}, 64'h0);
        check("rst_lo", {32'h0, lo}, 64'h0);
        @(negedge clock);

        // Directed corner cases
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        issue(2'b00, 32'hFFFF_FFFD, 32'h7);
        wait_done();
        issue(2'b10, 32'hFFFF_FFF9, 32'h2);     // back-to-back, in the done cycle
        wait_done();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        issue(2'b11, 32'h5, 32'h0);
        wait_done();
        issue(2'b10, 32'hFFFF_FFF0, 32'h0);
        wait_done();

        // Start while busy must be ignored
        issue(2'b01, 32'h1234, 32'h5678);
        repeat (4) @(negedge clock);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1111_1111;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        repeat (40) @(negedge clock);
        check("hold_hi", {32'h0, hi}, {32'h0, last_hi});
        check("hold_lo", {32'h0, lo}, {32'h0, last_lo});

        // Reset mid-operation discards it
        issue(2'b01, 32'h6, 32'h7);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        last_hi = 32'h0;
        last_lo = 32'h0;
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_hi", {32'h0, hi}, 64'h0);
        check("midrst_lo", {32'h0, lo}, 64'h0);
        repeat (40) @(negedge clock);
        issue(2'b01, 32'h6, 32'h7);
        wait_done();

        // Start coinciding with reset is ignored
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        op    = 2'b01;
        a     = 32'h9;
        b     = 32'h9;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        last_hi = 32'h0;
        last_lo = 32'h0;
        check("rst_start_busy", {63'h0, busy}, 64'h0);
        repeat (40) @(negedge clock);

        // Randomized traffic, mixing back-to-back and gapped issue
        for (int n = 0; n < 40; n++) begin
            issue(2'($urandom), pick_val(), pick_val());
            wait_done();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) @(negedge clock);
                check("hold_hi", {32'h0, hi}, {32'h0, last_hi});
                check("hold_lo", {32'h0, lo}, {32'h0, last_lo});
            end
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending results, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
